// File: rtl/multiplier_arbiter.sv
// Round-robin arbiter that shares one external multiplier among NUM_REQ requesters.
// Each grant runs one transaction: issue operands, wait for the result or a timeout, then respond.
module multiplier_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          clk_en_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_operand_A_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_operand_B_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          resp_valid_o,
  output logic [$clog2(NUM_REQ)-1:0]    resp_id_o,
  output logic [2*DATA_WIDTH-1:0]       resp_result_o,
  output logic                          resp_error_o,
  output logic [DATA_WIDTH-1:0]         mul_operand_A_o,
  output logic [DATA_WIDTH-1:0]         mul_operand_B_o,
  output logic                          mul_valid_entry_o,
  input  logic [2*DATA_WIDTH-1:0]       mul_result_i,
  input  logic                          mul_data_valid_i,
  input  logic                          mul_busy_i
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(TIMEOUT + 1);
  localparam int RW  = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

  state_t                state_q, state_d;
  logic [IDW-1:0]        ptr_q, ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
  logic [IDW-1:0]        id_q, id_d;
  logic [IDW-1:0]        resp_id_q, resp_id_d;
  logic [RW-1:0]         result_q, result_d;
  logic                  error_q, error_d;

  logic                  grant_found;
  logic [IDW-1:0]        grant_idx;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  mul_valid;
  logic                  resp_valid;
  logic [CW-1:0]         cnt_inc;

  // Search starts just after the last winner, so that winner has lowest priority.
  always_comb begin : rr_search
    int cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grant_found && req_valid_i[IDW'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(cand);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    id_d       = id_q;
    resp_id_d  = resp_id_q;
    result_d   = result_q;
    error_d    = error_q;
    req_ready  = '0;
    mul_valid  = 1'b0;
    resp_valid = 1'b0;
    cnt_inc    = cnt_q + CW'(1);
    if (clk_en_i) begin
      case (state_q)
        IDLE: begin
          if (grant_found && !mul_busy_i) begin
            req_ready[grant_idx] = 1'b1;
            ptr_d   = grant_idx;
            id_d    = grant_idx;
            op_a_d  = req_operand_A_i[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            op_b_d  = req_operand_B_i[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            state_d = ISSUE;
          end
        end
        ISSUE: begin
          mul_valid = 1'b1;
          cnt_d     = '0;
          state_d   = WAIT;
        end
        WAIT: begin
          // Valid data takes precedence over a timeout landing in the same cycle.
          if (mul_data_valid_i) begin
            result_d  = mul_result_i;
            error_d   = 1'b0;
            resp_id_d = id_q;
            state_d   = RESPOND;
          end else if (cnt_inc == CW'(TIMEOUT)) begin
            result_d  = '0;
            error_d   = 1'b1;
            resp_id_d = id_q;
            state_d   = RESPOND;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        RESPOND: begin
          resp_valid = 1'b1;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      ptr_q     <= IDW'(NUM_REQ - 1);
      cnt_q     <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      id_q      <= '0;
      resp_id_q <= '0;
      result_q  <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      id_q      <= id_d;
      resp_id_q <= resp_id_d;
      result_q  <= result_d;
      error_q   <= error_d;
    end
  end

  // Strobes are forced low while reset is held, even with requests pending.
  assign req_ready_o       = rst_n_i ? req_ready : '0;
  assign mul_valid_entry_o = rst_n_i & mul_valid;
  assign resp_valid_o      = rst_n_i & resp_valid;
  assign resp_id_o         = resp_id_q;
  assign resp_result_o     = result_q;
  assign resp_error_o      = error_q;
  assign mul_operand_A_o   = op_a_q;
  assign mul_operand_B_o   = op_b_q;

endmodule
